// File: rtl/dataram_ctrl.sv
// Dual-port (CPU/debug) arbiter and sequencer for a byte/bit addressable 8051 data RAM.
// Round-robin grant, address legality check, and a registered ISSUE/CAPTURE RAM handshake.
module dataram_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_req,
  input  logic [1:0] a_op,
  input  logic [7:0] a_addr,
  input  logic [7:0] a_wdata,
  output logic       a_ack,
  output logic [7:0] a_rdata,
  output logic       a_err,
  input  logic       b_req,
  input  logic [1:0] b_op,
  input  logic [7:0] b_addr,
  input  logic [7:0] b_wdata,
  output logic       b_ack,
  output logic [7:0] b_rdata,
  output logic       b_err,
  output logic       ram_cs_n,
  output logic       ram_rw,
  output logic       ram_bb,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_position,
  output logic [7:0] ram_din,
  output logic       ram_bin,
  input  logic [7:0] ram_dout,
  input  logic       ram_bout,
  output logic       busy
);

  localparam int unsigned DW = 8;
  localparam logic [DW-1:0] BIT_AREA_BASE = 8'h20;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_gnt_b;
  logic          r_last_b;
  logic [1:0]    r_op;

  logic          w_any_req;
  logic          w_grant_b;
  logic [1:0]    w_op;
  logic [DW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_illegal;
  logic [DW-1:0] w_map_addr;
  logic [DW-1:0] w_map_pos;

  logic          w_resp;
  logic          w_resp_b;
  logic [DW-1:0] w_resp_rdata;
  logic          w_resp_err;

  // Grant: B wins only when alone or when A was served last.
  assign w_any_req = a_req | b_req;
  assign w_grant_b = b_req & (~a_req | ~r_last_b);
  assign w_op      = w_grant_b ? b_op    : a_op;
  assign w_addr    = w_grant_b ? b_addr  : a_addr;
  assign w_wdata   = w_grant_b ? b_wdata : a_wdata;
  assign w_illegal = w_addr[DW-1];

  // Bit addresses 0x00-0x7F live in bytes 0x20-0x2F.
  assign w_map_addr = w_op[1] ? (BIT_AREA_BASE + DW'(w_addr[6:3])) : w_addr;
  assign w_map_pos  = w_op[1] ? (DW'(1) << w_addr[2:0]) : '0;

  // Response decode for the cycle that moves the FSM into DONE.
  always_comb begin
    w_resp       = 1'b0;
    w_resp_b     = r_gnt_b;
    w_resp_rdata = '0;
    w_resp_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req && w_illegal) begin
          w_resp     = 1'b1;
          w_resp_b   = w_grant_b;
          w_resp_err = 1'b1;
        end
      end
      S_ISSUE: begin
        w_resp = r_op[0];
      end
      S_CAPTURE: begin
        w_resp       = 1'b1;
        w_resp_rdata = r_op[1] ? {7'b0, ram_bout} : ram_dout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_gnt_b      <= 1'b0;
      r_last_b     <= 1'b1;
      r_op         <= '0;
      ram_cs_n     <= 1'b1;
      ram_rw       <= 1'b1;
      ram_bb       <= 1'b1;
      ram_addr     <= '0;
      ram_position <= '0;
      ram_din      <= '0;
      ram_bin      <= 1'b0;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
      a_err        <= 1'b0;
      b_err        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;

      if (w_resp) begin
        if (w_resp_b) begin
          b_ack   <= 1'b1;
          b_rdata <= w_resp_rdata;
          b_err   <= w_resp_err;
        end else begin
          a_ack   <= 1'b1;
          a_rdata <= w_resp_rdata;
          a_err   <= w_resp_err;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt_b <= w_grant_b;
            r_op    <= w_op;
            busy    <= 1'b1;
            if (w_illegal) begin
              r_state <= S_DONE;
            end else begin
              r_state      <= S_ISSUE;
              ram_cs_n     <= 1'b0;
              ram_rw       <= ~w_op[0];
              ram_bb       <= ~w_op[1];
              ram_addr     <= w_map_addr;
              ram_position <= w_map_pos;
              ram_din      <= w_op[1] ? '0 : w_wdata;
              ram_bin      <= w_op[1] & w_wdata[0];
            end
          end
        end
        S_ISSUE: begin
          if (r_op[0]) begin
            r_state  <= S_DONE;
            ram_cs_n <= 1'b1;
            ram_rw   <= 1'b1;
          end else begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          r_state  <= S_DONE;
          ram_cs_n <= 1'b1;
          ram_rw   <= 1'b1;
        end
        S_DONE: begin
          r_last_b <= r_gnt_b;
          r_state  <= S_IDLE;
          busy     <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dataram_ctrl.md
DATARAM_CTRL -- requirements
Module: dataram_ctrl

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-low; ports are named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 a_req / b_req  input  1  request from port A (CPU) / port B (debug); held with fields stable until ack.
REQ-005 a_op / b_op  input  2  00 byte read, 01 byte write, 10 bit read, 11 bit write.
REQ-006 a_addr / b_addr  input  8  byte address (byte ops) or 8051 bit address (bit ops).
REQ-007 a_wdata / b_wdata  input  8  write byte; bit writes use wdata[0].
REQ-008 a_ack / b_ack  output  1  one-cycle completion pulse.
REQ-009 a_rdata / b_rdata  output  8  read result, valid with ack; bit reads return {7'b0, bit}.
REQ-010 a_err / b_err  output  1  valid with ack; 1 = illegal address, no RAM access made.
REQ-011 ram_cs_n  output  1  RAM chip select, low active.
REQ-012 ram_rw  output  1  1 read, 0 write.
REQ-013 ram_bb  output  1  1 byte access, 0 bit access.
REQ-014 ram_addr  output  8  RAM byte address.
REQ-015 ram_position  output  8  one-hot bit select; 8'h00 for byte access.
REQ-016 ram_din / ram_bin  output  8 / 1  write data for byte / bit access.
REQ-017 ram_dout / ram_bout  input  8 / 1  RAM read data, valid one cycle after ram_cs_n falls.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, ISSUE, CAPTURE, DONE; all outputs are registered.
REQ-020 IDLE: no req -> stay in IDLE; otherwise grant per REQ-021, latch op/addr/wdata of the granted port, then go to ISSUE (legal request) or DONE with err=1 (illegal request).
REQ-021 Arbitration: round-robin on a last-grant flag; when both ports request, the port not granted last wins; a lone requester always wins.
REQ-022 Byte op legal range: addr 0x00-0x7F; 0x80-0xFF is illegal.
REQ-023 Bit op legal range: 0x00-0x7F; mapping ram_addr=0x20+addr[6:3], ram_position=1<<addr[2:0]; 0x80-0xFF is illegal.
REQ-024 ISSUE: ram_cs_n=0 for exactly one cycle, with ram_rw/ram_bb/ram_addr/ram_position/ram_din/ram_bin driven; a write commits at the end of this cycle; write -> DONE, read -> CAPTURE.
REQ-025 CAPTURE: ram_cs_n stays 0 with identical fields; ram_dout (byte) or ram_bout (bit) is sampled into rdata at the end of the cycle; then go to DONE.
REQ-026 DONE: ram_cs_n=1; the granted port's ack=1 for one cycle with rdata/err valid; last-grant updated; next state IDLE.
REQ-027 Latency from the IDLE cycle that samples req to ack high: write 2 cycles, read 3 cycles, error 1 cycle.
REQ-028 The non-granted port's ack stays 0; its req is held and is served on the next arbitration.
REQ-029 A req seen high in IDLE is a new request; the requester drops req on the edge where it samples ack.
REQ-030 rdata/err hold their last values between acks; a write ack returns rdata=0 and err=0.
REQ-031 In all states other than ISSUE and CAPTURE: ram_cs_n=1, ram_rw=1.

Reset
REQ-032 rst_n=0 at a clock edge forces: state IDLE, ram_cs_n=1, ram_rw=1, ram_bb=1, ram_addr=0, ram_position=0, ram_din=0, ram_bin=0, acks=0, rdata=0, errs=0, busy=0, last-grant=B (A wins the first tie).
REQ-033 Reset mid-operation aborts with no ack; a write whose ISSUE cycle coincides with the reset edge commits in RAM; the requester must reissue.

Verification
REQ-034 A byte write 0x45<-0xA5, then A byte read 0x45 -> write ack at cycle 2, read ack at cycle 3, a_rdata=0xA5, a_err=0.
REQ-035 A bit write 0x13<-1 -> ISSUE shows ram_addr=0x22, ram_position=0x08, ram_bb=0, ram_bin=1; bit read 0x13 -> a_rdata=0x01.
REQ-036 a_req and b_req both held continuously after reset, byte reads -> grants alternate A, B, A, B; each ack is seen only on its own port.
REQ-037 B bit read 0x85 -> b_ack at cycle 1, b_err=1, ram_cs_n never low.
REQ-038 rst_n low during CAPTURE of a read -> no ack; all outputs equal REQ-032 values on the next cycle.
